// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage CPU: opcodes, fetch state encoding and
// default datapath widths used by the fetch stage and its PC register.
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_INP  = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Opcode lives in the top nibble of an 8-bit instruction.
  function automatic logic [3:0] opcodeOf(input logic [7:0] instr);
    return instr[7:4];
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register for the fetch stage. Holds by default, increments
// or loads a new target, and also presents pc-1 so the fetch stage can
// re-request the instruction it is currently waiting on.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadVal,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcMinus1
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: a load (jump target) takes priority over a sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = loadVal;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC storage; reset restarts fetching from address zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pcMinus1 = pc_q - ADDR_W'(1);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: addresses the synchronous program ROM, captures instructions
// into the IR for decode, holds under stall and stops on HLT.
// Optional macro INSTR_FETCH_JMP_EN makes opcode JMP redirect the PC to its
// operand (with a refill bubble) instead of forwarding it to decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] ir_q;
  logic              irValid_q;
  logic [ADDR_W-1:0] irPc_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcMinus1;
  logic [3:0]        opcode;
  logic              advance;
  logic              isHlt;
  logic              isJmp;
  logic              pcInc;
  logic              pcLoad;

  assign opcode  = imem_data[DATA_W-1:DATA_W-4];
  assign advance = (state_q == RUN) && !stall;
  assign isHlt   = (opcode == OP_HLT);
`ifdef INSTR_FETCH_JMP_EN
  assign isJmp   = (opcode == OP_JMP);
`else
  assign isJmp   = 1'b0;
`endif

  // PC moves on every FILL edge and on every ordinary advance; HLT freezes it.
  assign pcInc  = (state_q == FILL) || (advance && !isHlt && !isJmp);
  assign pcLoad = advance && isJmp;

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pcInc),
    .load    (pcLoad),
    .loadVal (imem_data[ADDR_W-1:0]),
    .pc      (pc),
    .pcMinus1(pcMinus1)
  );

  // While stalled in RUN, re-request pc-1 so the ROM output stays valid for the release cycle.
  always_comb begin
    imem_addr = pc;
    if ((state_q == RUN) && stall) begin
      imem_addr = pcMinus1;
    end
  end

  // Fetch FSM with registered IR, valid, fetch address and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      ir_q      <= '0;
      irValid_q <= 1'b0;
      irPc_q    <= '0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          state_q <= RUN;
        end
        RUN: begin
          if (!stall) begin
            if (isHlt) begin
              irValid_q <= 1'b0;
              halted_q  <= 1'b1;
              state_q   <= HALT;
            end else if (isJmp) begin
              irValid_q <= 1'b0;
              state_q   <= FILL;
            end else begin
              ir_q      <= imem_data;
              irPc_q    <= pcMinus1;
              irValid_q <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign ir       = ir_q;
  assign ir_valid = irValid_q;
  assign ir_pc    = irPc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A program-order walk of the ROM
// produces the list of (address, instruction) pairs decode should see;
// the bench drives stall (directed or random) and checks the stream.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LIMIT = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic [AW-1:0] ir_pc;
  logic          halted;

  logic [DW-1:0] mem [DEPTH];

  int testsRun    = 0;
  int testsFailed = 0;

  logic [11:0]   expQ[$];
  bit            haltExpected;
  bit            truncated;
  logic [AW-1:0] hltAddr;

  instr_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall    (stall),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_pc    (ir_pc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: data for an address appears one edge later.
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Walk the program as the CPU would and list what decode must receive.
  task automatic buildExpected();
    int addr;
    int steps;
    logic [7:0] d;
    addr = 0;
    steps = 0;
    expQ.delete();
    haltExpected = 1'b0;
    truncated = 1'b0;
    hltAddr = '0;
    while (steps < 300 && expQ.size() < LIMIT) begin
      d = mem[addr];
      steps++;
      if (d[7:4] == OP_HLT) begin
        haltExpected = 1'b1;
        hltAddr = AW'(addr);
        break;
      end
`ifdef INSTR_FETCH_JMP_EN
      if (d[7:4] == OP_JMP) begin
        addr = int'(d[3:0]) % DEPTH;
        continue;
      end
`endif
      expQ.push_back({4'(addr), d});
      addr = (addr + 1) % DEPTH;
    end
    truncated = (expQ.size() == LIMIT);
  endtask

  task automatic applyStimulus(input int stallPct, input bit useTrigger, input logic [7:0] trigger,
                               input int expFirst, input int expHalt, input bit expConsec);
    logic [11:0]   e;
    logic [7:0]    curIr;
    logic [AW-1:0] curPc;
    logic [AW-1:0] expAddr;
    bit prevStall, prevHalted, lastValid, done, trigUsed;
    int trigLeft, edgeNo, firstEdge, lastEdge, haltEdge, delivered;

    buildExpected();
    stall = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("resetIr", 32'(ir), 32'h0);
    checkOutput("resetValid", 32'(ir_valid), 32'h0);
    checkOutput("resetIrPc", 32'(ir_pc), 32'h0);
    checkOutput("resetHalted", 32'(halted), 32'h0);
    checkOutput("resetAddr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    curIr = '0; curPc = '0;
    prevStall = 0; prevHalted = 0; lastValid = 0; done = 0; trigUsed = 0;
    trigLeft = 0; edgeNo = 0; firstEdge = -1; lastEdge = -1; haltEdge = 0; delivered = 0;

    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      @(negedge clk);
      edgeNo++;
      if (!prevStall && ir_valid) begin
        checkOutput("queueNonEmpty", 32'(expQ.size() > 0), 32'h1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          curPc = e[11:8];
          curIr = e[7:0];
          delivered++;
          if (firstEdge < 0) firstEdge = edgeNo;
          lastEdge = edgeNo;
        end
      end
      if (prevStall) checkOutput("validHeld", 32'(ir_valid), 32'(lastValid));
      checkOutput("ir", 32'(ir), 32'(curIr));
      checkOutput("irPc", 32'(ir_pc), 32'(curPc));
      if (halted && !prevHalted) begin
        haltEdge = edgeNo;
        checkOutput("haltOnStall", 32'(prevStall), 32'h0);
        checkOutput("haltEarly", 32'(expQ.size()), 32'h0);
        checkOutput("haltExpected", 32'(haltExpected), 32'h1);
      end
      if (prevHalted) checkOutput("haltSticky", 32'(halted), 32'h1);

      if (expQ.size() == 0) begin
        if (truncated) done = 1;
        else if (haltExpected) done = halted && (edgeNo >= haltEdge + 3);
        else done = (edgeNo >= 30);
      end

      if (useTrigger) begin
        if (trigLeft > 0) begin
          stall = 1'b1;
          trigLeft--;
        end else if (!trigUsed && ir_valid && curIr == trigger) begin
          trigUsed = 1;
          stall = 1'b1;
          trigLeft = 2;
        end else begin
          stall = 1'b0;
        end
      end else begin
        stall = ($urandom_range(0, 99) < stallPct);
      end

      #1;
      if (ir_valid) begin
        expAddr = curPc + (stall ? AW'(1) : AW'(2));
        checkOutput("imemAddrRun", 32'(imem_addr), 32'(expAddr));
      end
      if (halted) begin
        expAddr = hltAddr + AW'(1);
        checkOutput("imemAddrHalt", 32'(imem_addr), 32'(expAddr));
      end
      prevStall = stall;
      prevHalted = halted;
      lastValid = ir_valid;
    end

    checkOutput("timeout", 32'(done), 32'h1);
    if (!truncated) checkOutput("haltedFinal", 32'(halted), 32'(haltExpected));
    if (expFirst > 0) checkOutput("firstLatency", 32'(firstEdge), 32'(expFirst));
    if (expHalt > 0) checkOutput("haltEdge", 32'(haltEdge), 32'(expHalt));
    if (expConsec) checkOutput("throughput", 32'(lastEdge - firstEdge + 1), 32'(delivered));
    stall = 1'b0;
  endtask

  task automatic loadBasic();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    mem[3] = 8'h40; mem[4] = 8'h50; mem[5] = 8'hF0;
  endtask

  // Reset asserted between edges must clear the stage at once.
  task automatic midRunReset();
    bit seen;
    seen = 0;
    stall = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ir_valid && ir == 8'h30) seen = 1;
    end
    checkOutput("sawIr30", 32'(seen), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncIr", 32'(ir), 32'h0);
    checkOutput("asyncValid", 32'(ir_valid), 32'h0);
    checkOutput("asyncIrPc", 32'(ir_pc), 32'h0);
    checkOutput("asyncAddr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("refetchBubble", 32'(ir_valid), 32'h0);
    @(negedge clk);
    checkOutput("refetchIr", 32'(ir), 32'h10);
    checkOutput("refetchIrPc", 32'(ir_pc), 32'h0);
    checkOutput("refetchValid", 32'(ir_valid), 32'h1);
  endtask

  initial begin
    logic [3:0] op;
    int r;

    $display("[TB] sequential fetch");
    loadBasic();
    applyStimulus(0, 1'b0, 8'h00, 2, 7, 1'b1);

    $display("[TB] stall hold on 0x20");
    loadBasic();
    applyStimulus(0, 1'b1, 8'h20, 2, 10, 1'b0);

    $display("[TB] stall while HLT is on the bus");
    loadBasic();
    applyStimulus(0, 1'b1, 8'h50, 2, 10, 1'b0);

    $display("[TB] async reset mid-run");
    loadBasic();
    midRunReset();

    $display("[TB] JMP program");
    loadBasic();
    mem[1] = 8'h64; mem[2] = 8'h20; mem[3] = 8'h30; mem[4] = 8'h50;
`ifdef INSTR_FETCH_JMP_EN
    applyStimulus(0, 1'b0, 8'h00, 2, 6, 1'b0);
`else
    applyStimulus(0, 1'b0, 8'h00, 2, 7, 1'b1);
`endif

    $display("[TB] wrap-around");
    for (int i = 0; i < DEPTH; i++) begin
      op = 4'($urandom_range(0, 5));
      mem[i] = {op, 4'($urandom_range(0, 15))};
    end
    applyStimulus(0, 1'b0, 8'h00, 2, 0, 1'b1);

    $display("[TB] random programs with random stall");
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 99);
        op = (r < 8) ? OP_HLT : 4'($urandom_range(0, 14));
        mem[i] = {op, 4'($urandom_range(0, 15))};
      end
      applyStimulus(30, 1'b0, 8'h00, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the 3-stage CPU, directly upstream of sub_decoder.
- Drives the program-ROM address and captures the returned 8-bit instruction into an instruction register (IR).
- Presents the IR to decode with a valid flag, and holds it while decode/execute stalls.
- Detects HLT to stop fetching; with the optional feature, also redirects the PC on JMP.

Parameters:
- ADDR_W, 4, program-counter / ROM address width; the ROM holds 2^ADDR_W words.
- DATA_W, 8, instruction width. Opcode = bits [7:4]; operand = bits [3:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_addr  output  ADDR_W  ROM read address, combinational from state.
- imem_data  input  DATA_W  ROM read data. Synchronous ROM: valid the cycle after the address is presented.
- stall  input  1  downstream hold request. While high, the IR and PC do not advance.
- ir  output  DATA_W  instruction register, feeds the decoder's `a` input.
- ir_valid  output  1  IR holds a real instruction.
- ir_pc  output  ADDR_W  address the current IR was fetched from.
- halted  output  1  HLT fetched; fetching has stopped.

Behaviour:
- Reset (async, any state):
  - pc=0, ir=8'h00, ir_valid=0, ir_pc=0, halted=0, state=FILL.
  - Reset asserted mid-operation discards any in-flight ROM data.
- States: FILL, RUN, HALT.
- imem_addr:
  - = pc-1 (mod 2^ADDR_W) when state==RUN and stall==1.
  - = pc otherwise.
- FILL:
  - Requests pc. At the clock edge: pc<=pc+1, state<=RUN.
  - ir_valid stays 0. stall is ignored.
- RUN invariant: imem_data == mem[pc-1] every cycle.
- RUN, stall=0 (advance). At the edge:
  - ir<=imem_data, ir_pc<=pc-1, ir_valid<=1, pc<=pc+1.
- RUN, stall=1:
  - ir, ir_pc, ir_valid and pc are held.
  - Re-requesting pc-1 keeps imem_data valid for the cycle stall drops.
- HLT (opcode 4'hF) at the advance edge in RUN:
  - HLT is not forwarded.
  - ir_valid<=0, halted<=1, state<=HALT, pc frozen.
- HALT:
  - No register changes; imem_addr=pc.
  - Only reset exits this state.
- Latency: reset release to first ir_valid=1 is 2 edges. Throughput is 1 instruction/cycle when stall=0.
- Wrap-around:
  - pc and pc-1 wrap modulo 2^ADDR_W.
  - Fetch at address 2^ADDR_W-1 is followed by address 0 with no bubble.
- Unknown opcodes 4'h6–4'hE (4'h7–4'hE with JMP_EN) are forwarded unchanged; the decoder asserts no strobe for them.
- Simultaneous stall and HLT: stall wins. HLT is acted on only at the edge where it is actually captured.

Optional Feature:
- Macro: INSTR_FETCH_JMP_EN.
- Defined: opcode 4'h6 (JMP) at an advance edge in RUN:
  - pc<=operand[ADDR_W-1:0], ir_valid<=0 (one bubble), state<=FILL.
  - JMP is not forwarded to decode.
  - Min 2 edges from the JMP capture edge to the target instruction being valid.
- Undefined: 4'h6 is forwarded as an ordinary unknown opcode and the PC keeps incrementing.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants: OP_LOAD=4'h0, OP_ADD=4'h1, OP_SUB=4'h2, OP_AND=4'h3, OP_INP=4'h4, OP_OUT=4'h5, OP_JMP=4'h6, OP_HLT=4'hF.
  - Fetch state encoding: FILL/RUN/HALT.
  - Default ADDR_W/DATA_W.
- One sub-module, pc_reg:
  - Async-reset PC register with hold, increment and load inputs.
  - Exposes pc and pc_minus1.
- FSM and IR live in instr_fetch.

Test Plan:
- Sequential fetch:
  - Stimulus: ROM = 10,20,30,40,50,F0; stall=0; release reset.
  - Response: ir = 8'h10@pc0, 20@1, 30@2, 40@3, 50@4 on consecutive cycles; first ir_valid 2 edges after reset.
  - Then ir_valid=0 and halted=1; imem_addr constant at 6.
- Stall hold:
  - Stimulus: hold stall=1 for 3 cycles while ir=8'h20.
  - Response: ir/ir_pc/ir_valid unchanged and imem_addr=2 during the stall; ir=8'h30 on the first edge after stall drops.
- Wrap-around:
  - Stimulus: ADDR_W=2, ROM = 10,20,30,40, no HLT.
  - Response: ir_pc sequence 0,1,2,3,0,1 with ir_valid never dropping.
- Async reset mid-run:
  - Stimulus: assert rst between clock edges while ir=8'h30.
  - Response: ir=0, ir_valid=0, pc=0 immediately; refetch begins at address 0 after release.
- JMP (with INSTR_FETCH_JMP_EN):
  - Stimulus: ROM[1]=8'h64, ROM[4]=8'h50.
  - Response: after ir=ROM[0], one or more cycles of ir_valid=0, then ir=8'h50 with ir_pc=4.
  - Without the macro: ir=8'h64 is forwarded with ir_pc=1.
- Stall during HLT capture:
  - Stimulus: stall=1 while imem_data=8'hF0.
  - Response: halted stays 0 until stall drops; halted=1 at the following edge.
